// File: rtl/gap_state_detector.sv
// gap_state_detector: classifies each discharge pulse as OPEN/NORMAL/ARC/SHORT
// from the ignition delay measured on calibrated gap voltage and board current.
//
// Ports:
//   ad_clk          in   50 MHz sample clock
//   rst             in   synchronous active-high reset
//   sample_current  in   signed board current (A)
//   sample_voltage  in   signed gap voltage (V)
//   pulse_on        in   commanded pulse-on window
//   result_valid    out  one-cycle strobe per pulse
//   gap_state       out  0=OPEN 1=NORMAL 2=ARC 3=SHORT (held between strobes)
//   ign_delay       out  cycles from pulse start to breakdown onset, FFFF if OPEN
//   stat_clr        in   clear per-class counters          (GAP_STAT_EN only)
//   cnt_open/normal/arc/short out per-class pulse counters  (GAP_STAT_EN only)
//
// Optional feature macro: GAP_STAT_EN enables the per-class statistics counters.
module gap_state_detector #(
    parameter logic signed [15:0] V_BREAK   = 16'sd30,
    parameter logic signed [15:0] I_MIN     = 16'sd2,
    parameter int unsigned        DEB       = 3,
    parameter int unsigned        SHORT_DLY = 4,
    parameter int unsigned        ARC_DLY   = 50
) (
    input  logic               ad_clk,
    input  logic               rst,
    input  logic signed [15:0] sample_current,
    input  logic signed [15:0] sample_voltage,
    input  logic               pulse_on,
    output logic               result_valid,
    output logic [1:0]         gap_state,
    output logic [15:0]        ign_delay
`ifdef GAP_STAT_EN
    ,
    input  logic               stat_clr,
    output logic [15:0]        cnt_open,
    output logic [15:0]        cnt_normal,
    output logic [15:0]        cnt_arc,
    output logic [15:0]        cnt_short
`endif
);

    localparam logic [3:0]  DEB_C   = 4'(DEB);
    localparam logic [15:0] SHORT_C = 16'(SHORT_DLY);
    localparam logic [15:0] ARC_C   = 16'(ARC_DLY);
    localparam logic [15:0] DLY_MAX = 16'hFFFF;

    localparam logic [1:0] G_OPEN   = 2'd0;
    localparam logic [1:0] G_NORMAL = 2'd1;
    localparam logic [1:0] G_ARC    = 2'd2;
    localparam logic [1:0] G_SHORT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_REPORT
    } state_t;

    // input stage
    logic signed [15:0] r_v;
    logic signed [15:0] r_i;
    logic               r_pon;
    logic               r_pon_d;

    // measurement state
    state_t      r_state;
    logic [15:0] r_dcnt;
    logic [3:0]  r_rcnt;
    logic [15:0] r_onset;
    logic [1:0]  r_pend_gs;
    logic [15:0] r_pend_dly;

    // held results
    logic [1:0]  r_gs;
    logic [15:0] r_dly;

    // combinational
    state_t      w_next;
    logic        w_rise;
    logic        w_bd;
    logic [3:0]  w_run;
    logic [15:0] w_onset;
    logic        w_confirm;
    logic [1:0]  w_cls;
    logic        w_start;
    logic        w_pend_ld;
    logic        w_out_ld;
    logic [1:0]  w_out_gs;
    logic [15:0] w_out_dly;

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            r_v     <= '0;
            r_i     <= '0;
            r_pon   <= 1'b0;
            r_pon_d <= 1'b0;
        end else begin
            r_v     <= sample_voltage;
            r_i     <= sample_current;
            r_pon   <= pulse_on;
            r_pon_d <= r_pon;
        end
    end

    always_comb begin
        w_rise = r_pon & ~r_pon_d;
        w_bd   = (r_v < V_BREAK) && (r_i > I_MIN);
        w_run  = w_bd ? (r_rcnt + 4'd1) : 4'd0;
        // A new run (rcnt==0) restarts the onset at the current delay count.
        w_onset   = (w_bd && (r_rcnt == 4'd0)) ? r_dcnt : r_onset;
        w_confirm = w_bd && (w_run == DEB_C);
        if (w_onset < SHORT_C) begin
            w_cls = G_SHORT;
        end else if (w_onset < ARC_C) begin
            w_cls = G_ARC;
        end else begin
            w_cls = G_NORMAL;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_pend_ld = 1'b0;
        w_out_ld  = 1'b0;
        w_out_gs  = r_pend_gs;
        w_out_dly = r_pend_dly;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_next  = S_WAIT;
                    w_start = 1'b1;
                end
            end
            S_WAIT: begin
                // confirmation takes priority over a same-cycle pulse end
                if (w_confirm) begin
                    if (r_pon) begin
                        w_next    = S_DONE;
                        w_pend_ld = 1'b1;
                    end else begin
                        w_next    = S_REPORT;
                        w_out_ld  = 1'b1;
                        w_out_gs  = w_cls;
                        w_out_dly = w_onset;
                    end
                end else if (!r_pon) begin
                    w_next    = S_REPORT;
                    w_out_ld  = 1'b1;
                    w_out_gs  = G_OPEN;
                    w_out_dly = DLY_MAX;
                end
            end
            S_DONE: begin
                if (!r_pon) begin
                    w_next   = S_REPORT;
                    w_out_ld = 1'b1;
                end
            end
            S_REPORT: begin
                // a rise seen while reporting starts the next pulse directly
                if (w_rise) begin
                    w_next  = S_WAIT;
                    w_start = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dcnt     <= '0;
            r_rcnt     <= '0;
            r_onset    <= '0;
            r_pend_gs  <= '0;
            r_pend_dly <= '0;
            r_gs       <= '0;
            r_dly      <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_dcnt  <= '0;
                r_rcnt  <= '0;
                r_onset <= '0;
            end else if (r_state == S_WAIT) begin
                if (r_dcnt != DLY_MAX) begin
                    r_dcnt <= r_dcnt + 16'd1;
                end
                r_rcnt  <= w_run;
                r_onset <= w_onset;
            end
            if (w_pend_ld) begin
                r_pend_gs  <= w_cls;
                r_pend_dly <= w_onset;
            end
            if (w_out_ld) begin
                r_gs  <= w_out_gs;
                r_dly <= w_out_dly;
            end
        end
    end

    assign result_valid = (r_state == S_REPORT);
    assign gap_state    = r_gs;
    assign ign_delay    = r_dly;

`ifdef GAP_STAT_EN
    logic [15:0] r_cnt_open;
    logic [15:0] r_cnt_normal;
    logic [15:0] r_cnt_arc;
    logic [15:0] r_cnt_short;

    // results are already loaded into r_gs when REPORT is entered
    always_ff @(posedge ad_clk) begin
        if (rst || stat_clr) begin
            r_cnt_open   <= '0;
            r_cnt_normal <= '0;
            r_cnt_arc    <= '0;
            r_cnt_short  <= '0;
        end else if (r_state == S_REPORT) begin
            case (r_gs)
                G_OPEN: begin
                    if (r_cnt_open != DLY_MAX) begin
                        r_cnt_open <= r_cnt_open + 16'd1;
                    end
                end
                G_NORMAL: begin
                    if (r_cnt_normal != DLY_MAX) begin
                        r_cnt_normal <= r_cnt_normal + 16'd1;
                    end
                end
                G_ARC: begin
                    if (r_cnt_arc != DLY_MAX) begin
                        r_cnt_arc <= r_cnt_arc + 16'd1;
                    end
                end
                default: begin
                    if (r_cnt_short != DLY_MAX) begin
                        r_cnt_short <= r_cnt_short + 16'd1;
                    end
                end
            endcase
        end
    end

    assign cnt_open   = r_cnt_open;
    assign cnt_normal = r_cnt_normal;
    assign cnt_arc    = r_cnt_arc;
    assign cnt_short  = r_cnt_short;
`endif

endmodule

// File: tb/tb_gap_state_detector.sv
// tb_gap_state_detector: directed pulses with hand-computed classification,
// latency, reset-abort and back-to-back checks for gap_state_detector.
module tb_gap_state_detector;

    logic               ad_clk = 1'b0;
    logic               rst;
    logic signed [15:0] sample_current;
    logic signed [15:0] sample_voltage;
    logic               pulse_on;
    logic               result_valid;
    logic [1:0]         gap_state;
    logic [15:0]        ign_delay;
`ifdef GAP_STAT_EN
    logic               stat_clr;
    logic [15:0]        cnt_open;
    logic [15:0]        cnt_normal;
    logic [15:0]        cnt_arc;
    logic [15:0]        cnt_short;
`endif

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;

    gap_state_detector dut (
        .ad_clk         (ad_clk),
        .rst            (rst),
        .sample_current (sample_current),
        .sample_voltage (sample_voltage),
        .pulse_on       (pulse_on),
        .result_valid   (result_valid),
        .gap_state      (gap_state),
        .ign_delay      (ign_delay)
`ifdef GAP_STAT_EN
        ,
        .stat_clr       (stat_clr),
        .cnt_open       (cnt_open),
        .cnt_normal     (cnt_normal),
        .cnt_arc        (cnt_arc),
        .cnt_short      (cnt_short)
`endif
    );

    always #5 ad_clk = ~ad_clk;

    always @(negedge ad_clk) begin
        if (result_valid === 1'b1) n_strobe++;
    end

    // Port index c: value present at the c-th rising edge after pulse_on is raised.
    // One input register plus the IDLE->WAIT edge means index c is seen at dcnt=c-1,
    // so a confirming run starting at index b0 gives ign_delay = b0-1.
    // Columns: len, b0, b1 (breakdown [b0,b1)), g0, g1 (glitch), gs, delay
    int T_LEN[12] = '{200, 200, 200, 200, 200, 100, 100, 100, 100, 30, 30, 50};
    int T_B0 [12] = '{  0, 101,  21,   2,  81,   4,   5,  50,  51, 28, 28,  1};
    int T_B1 [12] = '{  0, 200, 200, 200, 200, 100, 100, 100, 100, 31, 30, 50};
    int T_G0 [12] = '{  0,   0,   0,   0,  11,   0,   0,   0,   0,  0,  0,  0};
    int T_G1 [12] = '{  0,   0,   0,   0,  13,   0,   0,   0,   0,  0,  0,  0};
    int T_GS [12] = '{  0,   1,   2,   3,   1,   3,   2,   2,   1,  2,  0,  3};
    int T_DLY[12] = '{'hFFFF, 100, 20, 1, 80, 3, 4, 49, 50, 27, 'hFFFF, 0};

    task automatic set_idle_inputs();
        pulse_on       = 1'b0;
        sample_voltage = 16'sd80;
        sample_current = 16'sd0;
    endtask

    task automatic drive_pulse(input int len, input int b0, input int b1,
                               input int g0, input int g1);
        logic b;
        for (int c = 0; c <= len; c++) begin
            b = ((c >= b0) && (c < b1)) || ((c >= g0) && (c < g1));
            pulse_on       = (c < len);
            sample_voltage = b ? 16'sd20 : 16'sd80;
            sample_current = b ? 16'sd10 : 16'sd0;
            @(posedge ad_clk); #1;
        end
        set_idle_inputs();
    endtask

    task automatic run_case(input int k);
        int n0;
        n0 = n_strobe;
        drive_pulse(T_LEN[k], T_B0[k], T_B1[k], T_G0[k], T_G1[k]);
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL case%0d early_valid got %b want 0", k, result_valid);
        end
        @(posedge ad_clk); #1;
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL case%0d valid got %b want 1", k, result_valid);
        end
        checks++;
        if (gap_state !== 2'(T_GS[k])) begin
            errors++;
            $display("FAIL case%0d gap_state got %0d want %0d", k, gap_state, T_GS[k]);
        end
        checks++;
        if (ign_delay !== 16'(T_DLY[k])) begin
            errors++;
            $display("FAIL case%0d ign_delay got %0h want %0h", k, ign_delay, T_DLY[k]);
        end
        @(posedge ad_clk); #1;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL case%0d valid_drop got %b want 0", k, result_valid);
        end
        checks++;
        if (gap_state !== 2'(T_GS[k]) || ign_delay !== 16'(T_DLY[k])) begin
            errors++;
            $display("FAIL case%0d hold got %0d/%0h want %0d/%0h",
                     k, gap_state, ign_delay, T_GS[k], T_DLY[k]);
        end
        checks++;
        if (n_strobe !== n0 + 1) begin
            errors++;
            $display("FAIL case%0d strobes got %0d want %0d", k, n_strobe - n0, 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle_inputs();
`ifdef GAP_STAT_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(posedge ad_clk);
        #1;
        checks++;
        if (result_valid !== 1'b0 || gap_state !== 2'd0 || ign_delay !== 16'd0) begin
            errors++;
            $display("FAIL reset outputs got %b/%0d/%0h want 0/0/0",
                     result_valid, gap_state, ign_delay);
        end
        rst = 1'b0;
        repeat (2) @(posedge ad_clk);
        #1;
    endtask

    task automatic test_classify();
        for (int k = 0; k < 12; k++) begin
            run_case(k);
            @(posedge ad_clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        logic b;
        n0 = n_strobe;
        // first pulse ARC at 20; second rises so its rise lands in REPORT
        drive_pulse(40, 21, 40, 0, 0);
        for (int c = 0; c <= 200; c++) begin
            b = (c >= 101) && (c < 200);
            pulse_on       = (c < 200);
            sample_voltage = b ? 16'sd20 : 16'sd80;
            sample_current = b ? 16'sd10 : 16'sd0;
            @(posedge ad_clk); #1;
            if (c == 0) begin
                checks++;
                if (result_valid !== 1'b1 || gap_state !== 2'd2 || ign_delay !== 16'd20) begin
                    errors++;
                    $display("FAIL b2b first got %b/%0d/%0d want 1/2/20",
                             result_valid, gap_state, ign_delay);
                end
            end
            if (c == 1) begin
                checks++;
                if (result_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b first_drop got %b want 0", result_valid);
                end
            end
        end
        set_idle_inputs();
        @(posedge ad_clk); #1;
        checks++;
        if (result_valid !== 1'b1 || gap_state !== 2'd1 || ign_delay !== 16'd100) begin
            errors++;
            $display("FAIL b2b second got %b/%0d/%0d want 1/1/100",
                     result_valid, gap_state, ign_delay);
        end
        @(posedge ad_clk); #1;
        checks++;
        if (n_strobe !== n0 + 2) begin
            errors++;
            $display("FAIL b2b strobes got %0d want 2", n_strobe - n0);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        logic b;
        n0 = n_strobe;
        for (int c = 0; c <= 51; c++) begin
            b = (c >= 30);
            pulse_on       = 1'b1;
            sample_voltage = b ? 16'sd20 : 16'sd80;
            sample_current = b ? 16'sd10 : 16'sd0;
            @(posedge ad_clk); #1;
        end
        rst = 1'b1;
        set_idle_inputs();
        @(posedge ad_clk); #1;
        rst = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || gap_state !== 2'd0 || ign_delay !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid outputs got %b/%0d/%0h want 0/0/0",
                     result_valid, gap_state, ign_delay);
        end
        repeat (6) @(posedge ad_clk);
        #1;
        checks++;
        if (n_strobe !== n0) begin
            errors++;
            $display("FAIL rst_mid strobes got %0d want 0", n_strobe - n0);
        end
        checks++;
        if (gap_state !== 2'd0 || ign_delay !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid hold got %0d/%0h want 0/0", gap_state, ign_delay);
        end
        run_case(1);
        @(posedge ad_clk); #1;
    endtask

`ifdef GAP_STAT_EN
    task automatic test_stats();
        stat_clr = 1'b1;
        @(posedge ad_clk); #1;
        stat_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_case(1);
            @(posedge ad_clk); #1;
        end
        run_case(2);
        @(posedge ad_clk); #1;
        checks++;
        if (cnt_normal !== 16'd3 || cnt_arc !== 16'd1 ||
            cnt_open !== 16'd0 || cnt_short !== 16'd0) begin
            errors++;
            $display("FAIL stats got o%0d n%0d a%0d s%0d want o0 n3 a1 s0",
                     cnt_open, cnt_normal, cnt_arc, cnt_short);
        end
        stat_clr = 1'b1;
        @(posedge ad_clk); #1;
        stat_clr = 1'b0;
        checks++;
        if (cnt_normal !== 16'd0 || cnt_arc !== 16'd0 ||
            cnt_open !== 16'd0 || cnt_short !== 16'd0) begin
            errors++;
            $display("FAIL stat_clr got o%0d n%0d a%0d s%0d want all 0",
                     cnt_open, cnt_normal, cnt_arc, cnt_short);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_classify();
        test_back_to_back();
        test_reset_mid();
`ifdef GAP_STAT_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
